// File: rtl/scan_seq_pkg.sv
// Shared types and default sizing for the scan-key sequencer.
// Default sizes come from the SCAN_KEY_* macros when mcse_def.svh is loaded; otherwise the fallbacks below apply.
`ifndef SCAN_KEY_WIDTH
`define SCAN_KEY_WIDTH 32
`endif
`ifndef SCAN_KEY_NUMBER
`define SCAN_KEY_NUMBER 8
`endif
`ifndef SCAN_UNLOCK_TIMEOUT
`define SCAN_UNLOCK_TIMEOUT 4
`endif

package scan_seq_pkg;
  localparam int DEF_KEY_WIDTH      = `SCAN_KEY_WIDTH;
  localparam int DEF_KEY_NUMBER     = `SCAN_KEY_NUMBER;
  localparam int DEF_UNLOCK_TIMEOUT = `SCAN_UNLOCK_TIMEOUT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_UNLOCK,
    ST_DONE,
    ST_FAIL
  } seq_state_t;
endpackage

// File: rtl/scan_key_sequencer_if.sv
// Request/key/status bundle between the sequencer and the system side.
// The master side requests sequences and reports the checker's unlock status.
interface scan_key_sequencer_if #(
  parameter int SCAN_KEY_WIDTH  = 32,
  parameter int SCAN_KEY_NUMBER = 8
);
  logic                                  start;
  logic [SCAN_KEY_WIDTH*SCAN_KEY_NUMBER-1:0] key_bundle;
  logic                                  scan_unlock;
  logic [SCAN_KEY_WIDTH-1:0]             scan_key;
  logic                                  busy;
  logic                                  done;
  logic                                  fail;

  modport master (
    output start, key_bundle, scan_unlock,
    input  scan_key, busy, done, fail
  );

  modport slave (
    input  start, key_bundle, scan_unlock,
    output scan_key, busy, done, fail
  );
endinterface

// File: rtl/scan_key_sequencer.sv
// Streams a latched multi-word key to the scan-control checker, then waits a bounded time for unlock.
// Optional build macro SCAN_SEQ_ZEROIZE_EN clears the key register when the sequence terminates.
module scan_key_sequencer
  import scan_seq_pkg::*;
#(
  parameter int                        SCAN_KEY_WIDTH  = DEF_KEY_WIDTH,
  parameter int                        SCAN_KEY_NUMBER = DEF_KEY_NUMBER,
  parameter logic [SCAN_KEY_WIDTH-1:0] IDLE_WORD       = '0,
  parameter int                        UNLOCK_TIMEOUT  = DEF_UNLOCK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  scan_key_sequencer_if.slave  bus
);
  localparam int KEY_BITS = SCAN_KEY_WIDTH * SCAN_KEY_NUMBER;
  localparam int IDX_W    = (SCAN_KEY_NUMBER > 1) ? $clog2(SCAN_KEY_NUMBER) : 1;
  localparam int CNT_W    = (UNLOCK_TIMEOUT > 1) ? $clog2(UNLOCK_TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCAN_KEY_NUMBER - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(UNLOCK_TIMEOUT - 1);

  seq_state_t          state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [KEY_BITS-1:0] key_reg, key_next;
  logic [SCAN_KEY_WIDTH-1:0] key_words [SCAN_KEY_NUMBER];

  for (genvar gi = 0; gi < SCAN_KEY_NUMBER; gi++) begin : g_word
    assign key_words[gi] = key_reg[gi*SCAN_KEY_WIDTH +: SCAN_KEY_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      key_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      key_reg   <= key_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    key_next   = key_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (bus.start) begin
          key_next   = bus.key_bundle;
          idx_next   = '0;
          cnt_next   = '0;
          // An already-unlocked checker needs no key words at all.
          state_next = bus.scan_unlock ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (idx_reg == LAST_IDX) begin
          state_next = ST_WAIT_UNLOCK;
          cnt_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      ST_WAIT_UNLOCK: begin
        if (bus.scan_unlock) begin
          state_next = ST_DONE;
        end else if (cnt_reg == LAST_CNT) begin
          state_next = ST_FAIL;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
`ifdef SCAN_SEQ_ZEROIZE_EN
    // Key material never lingers once the sequence has terminated.
    if (state_next == ST_DONE || state_next == ST_FAIL) begin
      key_next = '0;
    end
`else
`endif
  end

  assign bus.scan_key = (state_reg == ST_SEND) ? key_words[idx_reg] : IDLE_WORD;
  assign bus.busy     = (state_reg == ST_SEND) || (state_reg == ST_WAIT_UNLOCK);
  assign bus.done     = (state_reg == ST_DONE);
  assign bus.fail     = (state_reg == ST_FAIL);
endmodule

// File: tb/tb_scan_key_sequencer.sv
// Self-checking bench for scan_key_sequencer with a behavioural scan-control checker model.
// Honours SCAN_SEQ_ZEROIZE_EN when predicting the key register after a sequence ends.
module tb_scan_key_sequencer;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int TO = 4;
  localparam logic [W*N-1:0] KV_KEY =
    256'h87A5E932FA1BC49DFF8A0B2C3D4E5F607891ABCDEF0123456789ABCDEF012345;
  localparam logic [W-1:0] KV_WORDS [N] = '{32'hEF012345, 32'h6789ABCD, 32'hEF012345,
    32'h7891ABCD, 32'h3D4E5F60, 32'hFF8A0B2C, 32'hFA1BC49D, 32'h87A5E932};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_clear = 1'b0;
  logic force_unlock = 1'b0;
  logic chk_unlock = 1'b0;
  int   chk_delay = 2;
  int   chk_pend = 0;
  logic [W-1:0] chk_secret [N];
  logic [W-1:0] hist [N];
  int checks = 0;
  int failures = 0;

  scan_key_sequencer_if #(.SCAN_KEY_WIDTH(W), .SCAN_KEY_NUMBER(N)) bus();

  scan_key_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.scan_unlock = chk_unlock | force_unlock;

  always #5 clk = ~clk;

  // Checker model: unlocks chk_delay cycles after the last N observed words equal the secret.
  function automatic bit seq_match();
    bit m = (bus.scan_key === chk_secret[N-1]);
    for (int i = 1; i < N; i++) if (hist[i] !== chk_secret[i-1]) m = 1'b0;
    return m;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N-1; i++) hist[i] <= hist[i+1];
    hist[N-1] <= bus.scan_key;
    if (chk_clear) begin
      chk_unlock <= 1'b0;
      chk_pend   <= 0;
    end else if (chk_pend > 0) begin
      if (chk_pend == 1) chk_unlock <= 1'b1;
      chk_pend <= chk_pend - 1;
    end else if (!chk_unlock && seq_match()) begin
      if (chk_delay <= 1) chk_unlock <= 1'b1;
      else chk_pend <= chk_delay - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_checker(input logic [W*N-1:0] secret, input int delay);
    for (int i = 0; i < N; i++) chk_secret[i] = secret[i*W +: W];
    chk_delay = delay;
    chk_clear = 1'b1;
    tick();
    chk_clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+2:0] got;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.key_bundle = KV_KEY;
    tick();
    tick();
    got = {bus.scan_key, bus.busy, bus.done, bus.fail};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", got);
    end
    checks++;
    if (dut.key_reg !== '0) begin
      failures++;
      $display("FAIL reset_key_reg got=%h want=0", dut.key_reg);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority busy got=%b want=0", bus.busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_known_vector();
    logic [W+2:0] got, want;
    logic [W*N-1:0] want_kr;
    arm_checker(KV_KEY, 2);
    bus.key_bundle = KV_KEY;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      want = {(c <= N) ? KV_WORDS[c-1] : {W{1'b0}}, 1'(c < 11), 1'(c == 11), 1'b0};
      got  = {bus.scan_key, bus.busy, bus.done, bus.fail};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL known_vector cycle=%0d got=%h want=%h", c, got, want);
      end
      if (c < 11) tick();
    end
`ifdef SCAN_SEQ_ZEROIZE_EN
    want_kr = '0;
`else
    want_kr = KV_KEY;
`endif
    checks++;
    if (dut.key_reg !== want_kr) begin
      failures++;
      $display("FAIL key_reg_after_done got=%h want=%h", dut.key_reg, want_kr);
    end
    $display("test_known_vector done");
  endtask

  task automatic test_wrong_key();
    logic [W+2:0] got, want;
    arm_checker(KV_KEY, 2);
    bus.key_bundle = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= N + 1 + TO; c++) begin
      want = {{W{1'b0}}, 1'(c < N + 1 + TO), 1'b0, 1'(c == N + 1 + TO)};
      got  = {bus.scan_key, bus.busy, bus.done, bus.fail};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL wrong_key cycle=%0d got=%h want=%h", c, got, want);
      end
      if (c < N + 1 + TO) tick();
    end
    $display("test_wrong_key done");
  endtask

  task automatic test_start_ignored();
    logic [W+2:0] got, want;
    logic [W*N-1:0] want_kr;
    arm_checker(KV_KEY, 2);
    bus.key_bundle = KV_KEY;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      want = {(c <= N) ? KV_WORDS[c-1] : {W{1'b0}}, 1'(c < 11), 1'(c == 11), 1'b0};
      got  = {bus.scan_key, bus.busy, bus.done, bus.fail};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL start_while_busy cycle=%0d got=%h want=%h", c, got, want);
      end
      bus.start = (c == 3);
      bus.key_bundle = (c == 3) ? ~KV_KEY : KV_KEY;
      if (c < 11) tick();
    end
    bus.start = 1'b0;
`ifdef SCAN_SEQ_ZEROIZE_EN
    want_kr = '0;
`else
    want_kr = KV_KEY;
`endif
    checks++;
    if (dut.key_reg !== want_kr) begin
      failures++;
      $display("FAIL start_while_busy_key_reg got=%h want=%h", dut.key_reg, want_kr);
    end
    $display("test_start_ignored done");
  endtask

  task automatic test_rst_mid_send();
    logic [W+2:0] got;
    arm_checker(KV_KEY, 2);
    bus.key_bundle = KV_KEY;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    checks++;
    if (bus.scan_key !== KV_WORDS[4]) begin
      failures++;
      $display("FAIL rst_mid_send_pre got=%h want=%h", bus.scan_key, KV_WORDS[4]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      got = {bus.scan_key, bus.busy, bus.done, bus.fail};
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL rst_mid_send cycle=%0d got=%h want=0", c, got);
      end
      tick();
    end
    $display("test_rst_mid_send done");
  endtask

  task automatic test_already_unlocked();
    logic [W+2:0] got, want;
    arm_checker(KV_KEY, 2);
    force_unlock = 1'b1;
    bus.key_bundle = KV_KEY;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    want = {{W{1'b0}}, 1'b0, 1'b1, 1'b0};
    for (int c = 1; c <= 2; c++) begin
      got = {bus.scan_key, bus.busy, bus.done, bus.fail};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL already_unlocked cycle=%0d got=%h want=%h", c, got, want);
      end
      tick();
    end
    force_unlock = 1'b0;
    $display("test_already_unlocked done");
  endtask

  task automatic test_random();
    logic [W*N-1:0] key, secret, want_kr;
    logic [W+2:0] got, want;
    bit ok;
    int d, fin;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) key[i*W +: W] = $urandom();
      ok = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(1, TO + 1);
      secret = key;
      if (!ok) secret[(N-1)*W] = ~key[(N-1)*W];
      arm_checker(secret, d);
      repeat ($urandom_range(0, 2)) tick();
      ok  = ok && (d <= TO);
      fin = ok ? (N + d + 1) : (N + 1 + TO);
      bus.key_bundle = key;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= fin; c++) begin
        want = {(c <= N) ? key[(c-1)*W +: W] : {W{1'b0}}, 1'(c < fin),
                1'(c == fin && ok), 1'(c == fin && !ok)};
        got  = {bus.scan_key, bus.busy, bus.done, bus.fail};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL random txn=%0d cycle=%0d got=%h want=%h", t, c, got, want);
        end
        if (c < fin) tick();
      end
`ifdef SCAN_SEQ_ZEROIZE_EN
      want_kr = '0;
`else
      want_kr = key;
`endif
      checks++;
      if (dut.key_reg !== want_kr) begin
        failures++;
        $display("FAIL random_key_reg txn=%0d got=%h want=%h", t, dut.key_reg, want_kr);
      end
      $display("txn %0d delay=%0d unlock=%0d end_cycle=%0d", t, d, ok, fin);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.key_bundle = '0;
    for (int i = 0; i < N; i++) chk_secret[i] = '1;
    test_reset();
    test_known_vector();
    test_wrong_key();
    test_start_ignored();
    test_rst_mid_send();
    test_already_unlocked();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scan_key_sequencer.md
SCAN_KEY_SEQUENCER -- requirements
Module: scan_key_sequencer

Interface
REQ-001 SHALL have parameter SCAN_KEY_WIDTH, default `SCAN_KEY_WIDTH (32), width of one key word.
REQ-002 SHALL have parameter SCAN_KEY_NUMBER, default `SCAN_KEY_NUMBER (8), number of words per unlock sequence.
REQ-003 SHALL have parameter IDLE_WORD, default 0, value driven on scan_key when not sending.
REQ-004 SHALL have parameter UNLOCK_TIMEOUT, default 4, maximum wait cycles for scan_unlock after the last word.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  single-cycle request to send a sequence.
REQ-009 key_bundle  input  SCAN_KEY_WIDTH*SCAN_KEY_NUMBER  full key; word i = key_bundle[i*SCAN_KEY_WIDTH +: SCAN_KEY_WIDTH].
REQ-010 scan_unlock  input  1  unlock status returned by the scan-control checker.
REQ-011 scan_key  output  SCAN_KEY_WIDTH  word presented to the checker.
REQ-012 busy  output  1  high while a sequence is loading, sending or awaiting unlock.
REQ-013 done  output  1  sticky; unlock confirmed.
REQ-014 fail  output  1  sticky; timeout expired without unlock.

Function
REQ-015 FSM states SHALL be IDLE, SEND, WAIT_UNLOCK, DONE, FAIL.
REQ-016 start SHALL be accepted only in IDLE, DONE or FAIL and ignored while busy=1.
REQ-017 On accepted start, key_bundle SHALL be latched into an internal register, done and fail cleared, word index set to 0, state set to SEND.
REQ-018 If scan_unlock=1 when start is accepted, the FSM SHALL go directly to DONE, drive no words, and assert done on the next cycle.
REQ-019 In SEND, scan_key SHALL carry word k for exactly one cycle, k = 0..SCAN_KEY_NUMBER-1 in ascending order, with no gaps.
REQ-020 Word 0 SHALL appear in the cycle after start is sampled; word N-1 SHALL appear N cycles after start.
REQ-021 After word N-1, the FSM SHALL enter WAIT_UNLOCK, drive IDLE_WORD, and clear the wait counter.
REQ-022 In WAIT_UNLOCK, scan_unlock=1 SHALL move the FSM to DONE; done SHALL assert the following cycle.
REQ-023 In WAIT_UNLOCK, the wait counter SHALL increment each cycle; reaching UNLOCK_TIMEOUT with scan_unlock=0 SHALL move the FSM to FAIL and assert fail.
REQ-024 Nominal unlock against the checker SHALL occur 2 cycles after word N-1, inside the default timeout.
REQ-025 The word index and wait counter SHALL be $clog2 sized with no wrap; the index SHALL saturate at N-1.
REQ-026 done and fail SHALL never both be 1.
REQ-027 busy SHALL equal 1 exactly in SEND and WAIT_UNLOCK.
REQ-028 scan_key SHALL equal IDLE_WORD in every state except SEND.

Reset
REQ-029 rst SHALL force IDLE, scan_key=IDLE_WORD, busy=0, done=0, fail=0, index=0, counter=0, key register=0.
REQ-030 rst SHALL take priority over start in the same cycle.
REQ-031 rst asserted mid-sequence SHALL abort with no further words driven.

Configuration
REQ-032 Macro SCAN_SEQ_ZEROIZE_EN defined: the key register SHALL be cleared to 0 in the cycle the FSM enters DONE or FAIL.
REQ-033 Macro SCAN_SEQ_ZEROIZE_EN undefined: the key register SHALL retain its value until the next accepted start or rst.

Structure
REQ-034 Package scan_seq_pkg SHALL hold the FSM state enum and the default width, number and timeout constants, sourced from mcse_def.svh.
REQ-035 No sub-module SHALL be used; word select and the timeout counter SHALL be inline.

Verification
REQ-036 Key 256'h87A5E932FA1BC49DFF8A0B2C3D4E5F607891ABCDEF0123456789ABCDEF012345 with start at cycle 0 -> scan_key = EF012345, 6789ABCD, EF012345, 7891ABCD, 3D4E5F60, FF8A0B2C, FA1BC49D, 87A5E932 in cycles 1..8; with the checker attached, done=1 by cycle 11 and fail=0.
REQ-037 Wrong key (all zero), checker attached -> 8 words sent, fail=1 at cycle 8+1+4, done=0, busy=0.
REQ-038 start pulsed at cycle 3 during SEND -> sequence unchanged, no restart.
REQ-039 rst at cycle 5 mid-SEND -> scan_key=0 from cycle 6, busy=0, done=0, fail=0.
REQ-040 scan_unlock already 1 at start -> no words driven, done=1 at cycle 2.
REQ-041 With SCAN_SEQ_ZEROIZE_EN defined, key register=0 after DONE; undefined, key register=the latched key after DONE.
